scr1_dp_memory_init: RTL and testbench

- Parametrised dual-port synchronous TCM RAM with per-byte write enables on port B.
- Adds four things to the previous dual-port RAM generation:
  - a hardware zero-initialisation sequencer run after every reset;
  - a selectable read-during-write policy;
  - an optional output pipeline register;
  - per-port read-valid strobes.
- Sits between the TCM router and the core IMEM/DMEM paths.
- Port A serves instruction fetch (read-only); port B serves data (read/write).

---
 rtl/scr1_dp_memory_init_if.sv | 64 ++++++
 rtl/scr1_dp_memory_init.sv | 225 ++++++++++++++++++++++
 tb/tb_scr1_dp_memory_init.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_dp_memory_init_if.sv
// ---------------------------------------------------------------------------
// scr1_dp_memory_init_if
//
// Bus bundle between the TCM router (master) and the dual-port TCM RAM
// (slave). Clock and reset are kept outside the bundle as plain ports.
//
// Signals:
//   init_done        slave->master  array initialised; requests accepted only
//                                   while high
//   rena, addra      master->slave  port A (fetch) read request, word address
//   qa, qa_vld       slave->master  port A read data, one-cycle data strobe
//   renb, wenb       master->slave  port B (data) read / write requests
//   webb             master->slave  port B byte-lane enables
//   addrb, datab     master->slave  port B word address and write data
//   qb, qb_vld       slave->master  port B read data, one-cycle data strobe
//   wr_coll          slave->master  port A read and port B write hit the same
//                                   word; aligned with qa_vld
// ---------------------------------------------------------------------------
interface scr1_dp_memory_init_if #(
  parameter int SCR1_WIDTH  = 32,
  parameter int SCR1_SIZE   = 65536,
  parameter int SCR1_NBYTES = SCR1_WIDTH / 8
);

  localparam int ADDR_W = $clog2(SCR1_SIZE) - 2;

  logic                   init_done;

  logic                   rena;
  logic [ADDR_W-1:0]      addra;
  logic [SCR1_WIDTH-1:0]  qa;
  logic                   qa_vld;

  logic                   renb;
  logic                   wenb;
  logic [SCR1_NBYTES-1:0] webb;
  logic [ADDR_W-1:0]      addrb;
  logic [SCR1_WIDTH-1:0]  datab;
  logic [SCR1_WIDTH-1:0]  qb;
  logic                   qb_vld;

  logic                   wr_coll;

  // Router side: issues requests, consumes read data and status.
  modport master (
    input  init_done,
    output rena, addra,
    input  qa, qa_vld,
    output renb, wenb, webb, addrb, datab,
    input  qb, qb_vld,
    input  wr_coll
  );

  // Memory side: accepts requests, returns read data and status.
  modport slave (
    output init_done,
    input  rena, addra,
    output qa, qa_vld,
    input  renb, wenb, webb, addrb, datab,
    output qb, qb_vld,
    output wr_coll
  );

endinterface

// File: rtl/scr1_dp_memory_init.sv
// ---------------------------------------------------------------------------
// scr1_dp_memory_init
//
// Dual-port synchronous TCM RAM. Port A is a read-only instruction-fetch
// port, port B is a read/write data port with per-byte write enables.
// After every reset a sequencer zero-fills the whole array (optional), and
// requests are only accepted once init_done is high. Read-during-write on the
// same word returns either the old word or the byte-merged new word, and an
// optional output register adds one cycle of read latency.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset (array contents are not reset)
//   bus    scr1_dp_memory_init_if slave modport (requests, read data,
//          read-valid strobes, init_done, wr_coll)
// ---------------------------------------------------------------------------
module scr1_dp_memory_init #(
  parameter int SCR1_WIDTH   = 32,
  parameter int SCR1_SIZE    = 65536,
  parameter int SCR1_NBYTES  = SCR1_WIDTH / 8,
  parameter int SCR1_OUT_REG = 0,
  parameter int SCR1_INIT_EN = 1,
  parameter int SCR1_RDW_NEW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  scr1_dp_memory_init_if.slave  bus
);

  // Address range equals the depth exactly, so no wrap handling is needed.
  localparam int                ADDR_W    = $clog2(SCR1_SIZE) - 2;
  localparam int                DEPTH     = SCR1_SIZE / SCR1_NBYTES;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [ADDR_W-1:0]      fill_cnt_q;
  logic [ADDR_W-1:0]      fill_cnt_d;
  logic                   fill_we;
  logic                   init_done;

  logic [SCR1_WIDTH-1:0]  mem [DEPTH];

  logic                   acc_ra;
  logic                   acc_rb;
  logic                   acc_wb;
  logic                   same_word;
  logic                   coll;
  logic [SCR1_WIDTH-1:0]  rd_old_a;
  logic [SCR1_WIDTH-1:0]  rd_old_b;
  logic [SCR1_WIDTH-1:0]  merged_b;
  logic [SCR1_WIDTH-1:0]  rd_a;
  logic [SCR1_WIDTH-1:0]  rd_b;

  logic [SCR1_WIDTH-1:0]  qa_s1;
  logic [SCR1_WIDTH-1:0]  qb_s1;
  logic                   qa_vld_s1;
  logic                   qb_vld_s1;
  logic                   coll_s1;

  // ---------------------------------------------------------------------
  // Init sequencer state register. Reset aborts any fill in progress and
  // the next fill restarts from word 0.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Init sequencer next-state and outputs. IDLE lasts exactly one cycle,
  // FILL writes one zero word per cycle for DEPTH cycles, READY is
  // terminal until the next reset.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    fill_we    = 1'b0;
    init_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = (SCR1_INIT_EN != 0) ? ST_FILL : ST_READY;
      end
      ST_FILL: begin
        fill_we    = 1'b1;
        fill_cnt_d = fill_cnt_q + ADDR_W'(1);
        if (fill_cnt_q == LAST_WORD) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        init_done = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.init_done = init_done;

  // Requests only count once the array holds defined contents.
  assign acc_ra    = init_done & bus.rena;
  assign acc_rb    = init_done & bus.renb;
  assign acc_wb    = init_done & bus.wenb;
  assign same_word = (bus.addra == bus.addrb);
  assign coll      = acc_ra & acc_wb & same_word;

  assign rd_old_a  = mem[bus.addra];
  assign rd_old_b  = mem[bus.addrb];

  // Word at addrb as it will look after this cycle's port B write; lanes
  // without an enable keep the stored bytes.
  always_comb begin
    merged_b = rd_old_b;
    for (int i = 0; i < SCR1_NBYTES; i++) begin
      if (bus.webb[i]) begin
        merged_b[8*i +: 8] = bus.datab[8*i +: 8];
      end
    end
  end

  // With the new-data policy both ports forward the merged word when the
  // port B write targets the word they read; merged_b already equals the
  // old word when webb is all zero.
  assign rd_b = ((SCR1_RDW_NEW != 0) && acc_wb) ? merged_b : rd_old_b;
  assign rd_a = ((SCR1_RDW_NEW != 0) && acc_wb && same_word) ? merged_b : rd_old_a;

  // ---------------------------------------------------------------------
  // Array write port: the fill sequencer owns it until init_done, after
  // which accepted port B writes update only the enabled byte lanes.
  // No reset here, the array contents survive reset.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[fill_cnt_q] <= '0;
    end else if (acc_wb) begin
      for (int i = 0; i < SCR1_NBYTES; i++) begin
        if (bus.webb[i]) begin
          mem[bus.addrb][8*i +: 8] <= bus.datab[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // First read stage: data registers load only on an accepted read so the
  // outputs hold their last value; strobes are single-cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa_s1     <= '0;
      qb_s1     <= '0;
      qa_vld_s1 <= 1'b0;
      qb_vld_s1 <= 1'b0;
      coll_s1   <= 1'b0;
    end else begin
      qa_vld_s1 <= acc_ra;
      qb_vld_s1 <= acc_rb;
      coll_s1   <= coll;
      if (acc_ra) begin
        qa_s1 <= rd_a;
      end
      if (acc_rb) begin
        qb_s1 <= rd_b;
      end
    end
  end

  generate
    if (SCR1_OUT_REG != 0) begin : g_out_reg
      logic [SCR1_WIDTH-1:0] qa_s2;
      logic [SCR1_WIDTH-1:0] qb_s2;
      logic                  qa_vld_s2;
      logic                  qb_vld_s2;
      logic                  coll_s2;

      // Optional output stage: strobes and collision flag travel with
      // the data so every output keeps its relative alignment.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          qa_s2     <= '0;
          qb_s2     <= '0;
          qa_vld_s2 <= 1'b0;
          qb_vld_s2 <= 1'b0;
          coll_s2   <= 1'b0;
        end else begin
          qa_vld_s2 <= qa_vld_s1;
          qb_vld_s2 <= qb_vld_s1;
          coll_s2   <= coll_s1;
          if (qa_vld_s1) begin
            qa_s2 <= qa_s1;
          end
          if (qb_vld_s1) begin
            qb_s2 <= qb_s1;
          end
        end
      end

      assign bus.qa      = qa_s2;
      assign bus.qb      = qb_s2;
      assign bus.qa_vld  = qa_vld_s2;
      assign bus.qb_vld  = qb_vld_s2;
      assign bus.wr_coll = coll_s2;
    end else begin : g_no_out_reg
      assign bus.qa      = qa_s1;
      assign bus.qb      = qb_s1;
      assign bus.qa_vld  = qa_vld_s1;
      assign bus.qb_vld  = qb_vld_s1;
      assign bus.wr_coll = coll_s1;
    end
  endgenerate

endmodule

// File: tb/tb_scr1_dp_memory_init.sv
// ---------------------------------------------------------------------------
// tb_scr1_dp_memory_init
//
// Drives two instances of the TCM RAM with identical stimulus:
//   dut0: 1-cycle read latency, old data on read-during-write
//   dut1: 2-cycle read latency, new (byte-merged) data on read-during-write
// Both use a 64-byte array (16 words) with hardware zero-fill enabled.
// Expected outputs come from a word-array reference model with a per-config
// latency delay.
// ---------------------------------------------------------------------------
module tb_scr1_dp_memory_init;

  localparam int W     = 32;
  localparam int SIZE  = 64;
  localparam int DEPTH = 16;
  localparam int INIT_CYCLES = 1 + DEPTH;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rena;
  logic        renb;
  logic        wenb;
  logic [3:0]  webb;
  logic [3:0]  addra;
  logic [3:0]  addrb;
  logic [31:0] datab;

  int n_assert = 0;
  int n_fail   = 0;

  scr1_dp_memory_init_if #(.SCR1_WIDTH(W), .SCR1_SIZE(SIZE)) if0 ();
  scr1_dp_memory_init_if #(.SCR1_WIDTH(W), .SCR1_SIZE(SIZE)) if1 ();

  assign if0.rena  = rena;
  assign if0.addra = addra;
  assign if0.renb  = renb;
  assign if0.wenb  = wenb;
  assign if0.webb  = webb;
  assign if0.addrb = addrb;
  assign if0.datab = datab;
  assign if1.rena  = rena;
  assign if1.addra = addra;
  assign if1.renb  = renb;
  assign if1.wenb  = wenb;
  assign if1.webb  = webb;
  assign if1.addrb = addrb;
  assign if1.datab = datab;

  scr1_dp_memory_init #(
    .SCR1_WIDTH(W), .SCR1_SIZE(SIZE), .SCR1_OUT_REG(0),
    .SCR1_INIT_EN(1), .SCR1_RDW_NEW(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave)
  );

  scr1_dp_memory_init #(
    .SCR1_WIDTH(W), .SCR1_SIZE(SIZE), .SCR1_OUT_REG(1),
    .SCR1_INIT_EN(1), .SCR1_RDW_NEW(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  bit          m_ready;
  int          m_since;
  logic [31:0] e_qa [2];
  logic [31:0] e_qb [2];
  logic        e_qav [2];
  logic        e_qbv [2];
  logic        e_coll [2];
  logic        p_av;
  logic        p_bv;
  logic        p_coll;
  logic [31:0] p_qa;
  logic [31:0] p_qb;

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("dut0.init_done", 32'(if0.init_done), 32'(m_ready));
    check("dut0.qa",        if0.qa,             e_qa[0]);
    check("dut0.qa_vld",    32'(if0.qa_vld),    32'(e_qav[0]));
    check("dut0.qb",        if0.qb,             e_qb[0]);
    check("dut0.qb_vld",    32'(if0.qb_vld),    32'(e_qbv[0]));
    check("dut0.wr_coll",   32'(if0.wr_coll),   32'(e_coll[0]));
    check("dut1.init_done", 32'(if1.init_done), 32'(m_ready));
    check("dut1.qa",        if1.qa,             e_qa[1]);
    check("dut1.qa_vld",    32'(if1.qa_vld),    32'(e_qav[1]));
    check("dut1.qb",        if1.qb,             e_qb[1]);
    check("dut1.qb_vld",    32'(if1.qb_vld),    32'(e_qbv[1]));
    check("dut1.wr_coll",   32'(if1.wr_coll),   32'(e_coll[1]));
  endtask

  // Present one cycle of inputs, advance the model across the clock edge,
  // then compare all outputs on the following falling edge.
  task automatic applyStimulus(input logic ra, input logic [3:0] aa,
                               input logic rb, input logic wb,
                               input logic [3:0] be, input logic [3:0] ab,
                               input logic [31:0] d);
    bit          acc;
    logic [31:0] a_old, b_old, a_new, b_new;
    bit          hit;
    rena  = ra;
    addra = aa;
    renb  = rb;
    wenb  = wb;
    webb  = be;
    addrb = ab;
    datab = d;
    @(posedge clk);
    acc   = m_ready;
    a_old = m_mem[aa];
    b_old = m_mem[ab];
    hit   = acc && wb && (aa == ab);
    b_new = (acc && wb) ? merge(b_old, d, be) : b_old;
    a_new = hit ? b_new : a_old;
    if (acc && wb) m_mem[ab] = b_new;
    if (!m_ready) begin
      m_since++;
      if (m_since == INIT_CYCLES) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      end
    end
    // dut0: data visible right after the request edge, old data
    e_qav[0]  = acc && ra;
    e_qbv[0]  = acc && rb;
    e_coll[0] = hit && ra;
    if (e_qav[0]) e_qa[0] = a_old;
    if (e_qbv[0]) e_qb[0] = b_old;
    // dut1: one more edge of delay, new data
    e_qav[1]  = p_av;
    e_qbv[1]  = p_bv;
    e_coll[1] = p_coll;
    if (p_av) e_qa[1] = p_qa;
    if (p_bv) e_qb[1] = p_qb;
    p_av   = acc && ra;
    p_bv   = acc && rb;
    p_coll = hit && ra;
    p_qa   = a_new;
    p_qb   = b_new;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  // Assert reset asynchronously, check the reset state, release on the
  // next falling edge.
  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    m_ready = 1'b0;
    m_since = 0;
    for (int k = 0; k < 2; k++) begin
      e_qa[k] = 32'h0; e_qb[k] = 32'h0;
      e_qav[k] = 1'b0; e_qbv[k] = 1'b0; e_coll[k] = 1'b0;
    end
    p_av = 1'b0; p_bv = 1'b0; p_coll = 1'b0; p_qa = 32'h0; p_qb = 32'h0;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic        r_ra, r_rb, r_wb;
    logic [3:0]  r_aa, r_ab, r_be;
    logic [31:0] r_d;

    rst_n = 1'b0;
    rena = 1'b0; renb = 1'b0; wenb = 1'b0;
    webb = 4'h0; addra = 4'h0; addrb = 4'h0; datab = 32'h0;
    @(negedge clk);

    $display("[TB] initial fill with requests pulsed during fill");
    applyReset();
    for (int i = 1; i <= INIT_CYCLES; i++) begin
      if (i == 6) applyStimulus(1'b1, 4'h9, 1'b1, 1'b1, 4'hF, 4'h9, 32'h55555555);
      else        idle();
    end
    check("init_done_after_17", 32'(if0.init_done), 32'h1);

    $display("[TB] fill array with ones, then reset mid-fill");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 4'hF, 4'(i), 32'hFFFFFFFF);
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    idle();
    check("ones_readback_dut1", if1.qa, 32'hFFFFFFFF);
    applyReset();
    for (int i = 0; i < 5; i++) idle();
    applyReset();
    check("midfill_qa_zero", if0.qa, 32'h0);
    for (int i = 1; i <= INIT_CYCLES; i++) idle();

    $display("[TB] zero readback of all words on port A");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    idle();
    check("zero_readback_w15", if1.qa, 32'h0);

    $display("[TB] byte-enable write");
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 4'hF, 4'h3, 32'h11223344);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 4'b0101, 4'h3, 32'hAABBCCDD);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h3, 32'h0);
    check("be_qb_dut0", if0.qb, 32'h11BB33DD);
    idle();
    check("be_qb_dut1", if1.qb, 32'h11BB33DD);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h3, 32'h99999999);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h3, 32'h0);
    idle();

    $display("[TB] read-during-write on word 7");
    applyStimulus(1'b1, 4'h7, 1'b1, 1'b1, 4'hF, 4'h7, 32'hDEADBEEF);
    check("rdw_qa_dut0", if0.qa, 32'h0);
    check("rdw_coll_dut0", 32'(if0.wr_coll), 32'h1);
    idle();
    check("rdw_qa_dut1", if1.qa, 32'hDEADBEEF);
    check("rdw_coll_dut1", 32'(if1.wr_coll), 32'h1);
    idle();

    $display("[TB] back-to-back reads through the output register");
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 4'hF, 4'h2, 32'h12345678);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 4'hF, 4'h3, 32'h0BADF00D);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 4'hF, 4'h4, 32'hCAFEBABE);
    applyStimulus(1'b1, 4'h2, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    check("outreg_no_early_vld", 32'(if1.qa_vld), 32'h0);
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    check("outreg_qa_t2", if1.qa, 32'h12345678);
    applyStimulus(1'b1, 4'h4, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    idle();
    idle();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 300; n++) begin
      r_ra = 1'($urandom);
      r_rb = 1'($urandom);
      r_wb = 1'($urandom);
      r_be = 4'($urandom);
      r_aa = 4'($urandom);
      r_ab = ($urandom_range(0, 3) == 0) ? r_aa : 4'($urandom);
      r_d  = $urandom;
      applyStimulus(r_ra, r_aa, r_rb, r_wb, r_be, r_ab, r_d);
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
